// File: rtl/mux_sel_pipe.sv
// rtl/mux_sel_pipe.sv - NUM_IN:1 select mux with registered 2-entry skid output stage (optional MUX_SEL_CHECK_EN)
module mux_sel_pipe #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        dout,
    output logic [1:0]              occ,
    output logic                    sel_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] m;
    logic [31:0]      sel_ext;
    logic             accept;
    logic             pop;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign sel_ext   = 32'(sel);
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != TWO);
    assign occ       = state;
    assign dout      = main_q;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Mux: out-of-range selects fall through to the all-zero default
    always_comb begin
        m = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_ext == 32'(k)) begin
                m = din[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and register load decode; flush overrides accept and pop
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Data registers: main drives dout, skid holds the younger word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= m;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= m;
            end
        end
    end

`ifdef MUX_SEL_CHECK_EN
    logic sel_oor;
    logic sel_err_q;

    assign sel_oor = (sel_ext >= 32'(NUM_IN));
    assign sel_err = sel_err_q;

    // One-cycle pulse for an out-of-range select that is actually enqueued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= accept & ~flush & sel_oor;
        end
    end
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb/tb_mux_sel_pipe.sv - self-checking bench for mux_sel_pipe
module tb_mux_sel_pipe;

`ifdef MUX_SEL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, sel_err;
    logic [1:0]  sel, occ;
    logic [19:0] din;
    logic [4:0]  dout;

    logic        in_valid3, in_ready3, flush3, out_valid3, out_ready3, sel_err3;
    logic [1:0]  sel3, occ3;
    logic [14:0] din3;
    logic [4:0]  dout3;

    int tests;
    int fails;

    mux_sel_pipe #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .din(din), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .dout(dout), .occ(occ), .sel_err(sel_err)
    );

    mux_sel_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .sel(sel3), .din(din3), .flush(flush3), .out_valid(out_valid3),
        .out_ready(out_ready3), .dout(dout3), .occ(occ3), .sel_err(sel_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [1:0]  s;
        logic [19:0] d;
        logic        e_ov;
        logic [4:0]  e_dout;
        logic [1:0]  e_occ;
        logic        e_ir;
    } vec_t;

    localparam logic [19:0] DA = {5'd3, 5'd2, 5'd1, 5'd0};
    localparam logic [19:0] DB = {5'd7, 5'd6, 5'd5, 5'd4};

    vec_t vecs[17];
    logic [4:0] q[$];
    logic [4:0] exp_m;
    logic [4:0] held;
    logic       stalled;
    logic       acc, pp;

    initial begin
        tests = 0;
        fails = 0;
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'd2, DA, 1'b1, 5'd2, 2'd1, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd2, DA, 1'b1, 5'd2, 2'd1, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'd2, DA, 1'b1, 5'd2, 2'd1, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'd0, DA, 1'b0, 5'd2, 2'd0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd1, DA, 1'b1, 5'd1, 2'd1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'd3, DA, 1'b1, 5'd1, 2'd2, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, DA, 1'b1, 5'd1, 2'd2, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, DA, 1'b1, 5'd3, 2'd1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd0, DA, 1'b0, 5'd3, 2'd0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd1, DB, 1'b1, 5'd5, 2'd1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2'd2, DB, 1'b1, 5'd5, 2'd2, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 2'd3, DB, 1'b0, 5'd5, 2'd0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 2'd0, DB, 1'b0, 5'd5, 2'd0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 2'd0, DA, 1'b0, 5'd5, 2'd0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 2'd3, DA, 1'b1, 5'd3, 2'd1, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 2'd0, DA, 1'b0, 5'd3, 2'd0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 2'd0, DA, 1'b0, 5'd3, 2'd0, 1'b1};

        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; flush = 0; sel = 0; din = DA;
        in_valid3 = 0; out_ready3 = 1; flush3 = 0; sel3 = 0; din3 = {5'd9, 5'd8, 5'd7};
        #12;
        chk("reset out_valid", out_valid, 0);
        chk("reset dout", dout, 0);
        chk("reset occ", occ, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset sel_err", sel_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: T1 steady select, T2 stall/skid, T3 flush cases
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = vecs[i].iv; out_ready = vecs[i].ordy; flush = vecs[i].fl;
            sel = vecs[i].s; din = vecs[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_ov);
            chk($sformatf("vec%0d dout", i), dout, vecs[i].e_dout);
            chk($sformatf("vec%0d occ", i), occ, vecs[i].e_occ);
            chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_ir);
            chk($sformatf("vec%0d sel_err", i), sel_err, 0);
        end

        // T4: asynchronous reset with both entries held
        @(negedge clk);
        in_valid = 1; out_ready = 0; flush = 0; sel = 2'd1; din = DB;
        @(negedge clk);
        sel = 2'd2;
        @(negedge clk);
        in_valid = 0;
        chk("t4 pre occ", occ, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4 out_valid", out_valid, 0);
        chk("t4 occ", occ, 0);
        chk("t4 dout", dout, 0);
        chk("t4 in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // T5: out-of-range select on the 3-input instance
        @(negedge clk);
        in_valid3 = 1; sel3 = 2'd3;
        @(posedge clk);
        #1;
        chk("t5 oor out_valid", out_valid3, 1);
        chk("t5 oor dout", dout3, 0);
        chk("t5 oor sel_err", sel_err3, int'(CHK));
        @(negedge clk);
        sel3 = 2'd2;
        @(posedge clk);
        #1;
        chk("t5 in-range dout", dout3, 9);
        chk("t5 pulse width", sel_err3, 0);
        @(negedge clk);
        sel3 = 2'd3; flush3 = 1;
        @(posedge clk);
        #1;
        chk("t5 flushed sel_err", sel_err3, 0);
        chk("t5 flushed out_valid", out_valid3, 0);
        @(negedge clk);
        in_valid3 = 0; flush3 = 0;

        // T6: random traffic against a FIFO model
        q.delete();
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (occ != 2'(q.size())) chk("t6 occ", occ, q.size());
            if (stalled) begin
                chk("t6 stall valid", out_valid, 1);
                chk("t6 stall dout", dout, held);
            end
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            sel = 2'($urandom_range(0, 3));
            din = 20'($urandom);
            #1;
            acc = in_valid & in_ready;
            pp = out_valid & out_ready;
            if (pp) begin
                if (q.size() == 0) chk("t6 underflow", 1, 0);
                else chk("t6 data", dout, q.pop_front());
            end
            if (acc) begin
                exp_m = din[sel*5 +: 5];
                q.push_back(exp_m);
            end
            stalled = out_valid & ~out_ready;
            held = dout;
        end
        @(negedge clk);
        in_valid = 0; out_ready = 1;
        chk("t6 final occ", occ, q.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
